// File: rtl/conv_3x3_dilation_feeder.sv
// conv_3x3_dilation_feeder
//
// Stream source for the dilated 3x3 convolution datapath. Holds a kernel
// loaded through a small register-write port. Each accepted `start` first
// sends the kernel on the weight stream, then turns a raw, unpadded
// feature-map stream into a zero-padded raster. The zero border is RATE
// pixels wide on every side.
//
// Optional feature: CONV_FEEDER_WEIGHT_REPLAY_EN
//   defined   : every frame begins with the weight phase.
//   undefined : the weight phase runs only when the kernel has changed since
//               it was last sent (dirty flag, set by reset and by accepted
//               kernel writes).
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   weight_we/addr/wdata  kernel register write (accepted only while idle)
//   start             begin one frame (ignored while busy)
//   valid_in, pxl_in  raw pixel stream; in_ready is the combinational accept
//   weight_out, valid_weight_out   weight stream to the convolution
//   pxl_out, valid_out             padded pixel stream to the convolution
//   busy              frame in progress; drops the cycle after done
//   done              one-cycle pulse alongside the last padded pixel
module conv_3x3_dilation_feeder #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int RATE         = 2,
  parameter int KERNEL_SIZE  = 9,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  weight_we,
  input  logic [3:0]            weight_addr,
  input  logic [DATA_WIDTH-1:0] weight_wdata,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = IMAGE_WIDTH + 2 * RATE;
  localparam int PH = IMAGE_HEIGHT + 2 * RATE;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(PW - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(PH - 1);
  localparam logic [CNT_WIDTH-1:0] PAD_LO   = CNT_WIDTH'(RATE);
  localparam logic [CNT_WIDTH-1:0] COL_HI   = CNT_WIDTH'(RATE + IMAGE_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ROW_HI   = CNT_WIDTH'(RATE + IMAGE_HEIGHT);
  localparam logic [3:0]           W_LAST   = 4'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WEIGHTS, PIXELS} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  row;
  logic [CNT_WIDTH-1:0]  col;
  logic [3:0]            widx;
  logic [DATA_WIDTH-1:0] kernel [KERNEL_SIZE];

  logic is_pad;
  logic last_pos;
  logic emit_pxl;
  logic start_ok;
  logic write_ok;
  logic load_weights;

`ifdef CONV_FEEDER_WEIGHT_REPLAY_EN
  assign load_weights = 1'b1;
`else
  logic dirty;
  assign load_weights = dirty;
`endif

  assign is_pad   = (row < PAD_LO) || (row >= ROW_HI) ||
                    (col < PAD_LO) || (col >= COL_HI);
  assign last_pos = (row == ROW_LAST) && (col == COL_LAST);

  // in_ready depends only on state and position, never on valid_in, so the
  // upstream source may wait for it without a combinational loop.
  assign in_ready = (state == PIXELS) && !is_pad;

  // A pad position emits every cycle; an interior one only on a handshake.
  assign emit_pxl = (state == PIXELS) && (is_pad || valid_in);

  // busy stays high through the done cycle, which keeps a start or kernel
  // write arriving alongside the last pixel from being taken.
  assign start_ok = start && !busy;
  assign write_ok = weight_we && !busy && (weight_addr <= W_LAST);

  // Kernel registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KERNEL_SIZE; i++) kernel[i] <= '0;
    end else if (write_ok) begin
      kernel[weight_addr] <= weight_wdata;
    end
  end

  // Sequencer and registered output stage. The transition that accepts
  // start already emits the first token, so it shows up one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      row              <= '0;
      col              <= '0;
      widx             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      valid_out        <= 1'b0;
      valid_weight_out <= 1'b0;
      pxl_out          <= '0;
      weight_out       <= '0;
`ifndef CONV_FEEDER_WEIGHT_REPLAY_EN
      dirty            <= 1'b1;
`endif
    end else begin
      valid_out        <= 1'b0;
      valid_weight_out <= 1'b0;
      done             <= 1'b0;
      if (done) busy <= 1'b0;
`ifndef CONV_FEEDER_WEIGHT_REPLAY_EN
      if (write_ok) dirty <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (start_ok) begin
            busy <= 1'b1;
            if (load_weights) begin
              weight_out       <= kernel[0];
              valid_weight_out <= 1'b1;
              widx             <= 4'd1;
              if (W_LAST == 4'd0) begin
                state <= PIXELS;
`ifndef CONV_FEEDER_WEIGHT_REPLAY_EN
                dirty <= 1'b0;
`endif
              end else begin
                state <= WEIGHTS;
              end
            end else begin
              state <= PIXELS;
              // With a border, (0,0) is always pad and can be emitted now;
              // without one it needs a handshake from the PIXELS state.
              if (RATE > 0) begin
                pxl_out   <= '0;
                valid_out <= 1'b1;
                col       <= CNT_WIDTH'(1);
              end
            end
          end
        end

        WEIGHTS: begin
          weight_out       <= kernel[widx];
          valid_weight_out <= 1'b1;
          if (widx == W_LAST) begin
            widx  <= '0;
            state <= PIXELS;
`ifndef CONV_FEEDER_WEIGHT_REPLAY_EN
            dirty <= 1'b0;
`endif
          end else begin
            widx <= widx + 4'd1;
          end
        end

        PIXELS: begin
          if (emit_pxl) begin
            valid_out <= 1'b1;
            pxl_out   <= is_pad ? '0 : pxl_in;
            if (last_pos) begin
              done  <= 1'b1;
              state <= IDLE;
              row   <= '0;
              col   <= '0;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_3x3_dilation_feeder.sv
// tb_conv_3x3_dilation_feeder
//
// Directed bench for conv_3x3_dilation_feeder built as a 4x4 image with a
// one-pixel border (6x6 padded frame). Expected frames and kernels are
// hand-written constants. Honours CONV_FEEDER_WEIGHT_REPLAY_EN when defined.
module tb_conv_3x3_dilation_feeder;

`ifdef CONV_FEEDER_WEIGHT_REPLAY_EN
  localparam int REPLAY = 1;
`else
  localparam int REPLAY = 0;
`endif

  logic        clk;
  logic        reset;
  logic        weight_we;
  logic [3:0]  weight_addr;
  logic [15:0] weight_wdata;
  logic        start;
  logic        valid_in;
  logic [15:0] pxl_in;
  logic        in_ready;
  logic [15:0] weight_out;
  logic        valid_weight_out;
  logic [15:0] pxl_out;
  logic        valid_out;
  logic        busy;
  logic        done;

  conv_3x3_dilation_feeder #(
    .DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .RATE(1), .KERNEL_SIZE(9), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .weight_we(weight_we), .weight_addr(weight_addr), .weight_wdata(weight_wdata),
    .start(start), .valid_in(valid_in), .pxl_in(pxl_in), .in_ready(in_ready),
    .weight_out(weight_out), .valid_weight_out(valid_weight_out),
    .pxl_out(pxl_out), .valid_out(valid_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Padded 6x6 frame for raw pixels 1..16 in raster order.
  int exp_frame [36] = '{
    0, 0,  0,  0,  0, 0,
    0, 1,  2,  3,  4, 0,
    0, 5,  6,  7,  8, 0,
    0, 9, 10, 11, 12, 0,
    0, 13, 14, 15, 16, 0,
    0, 0,  0,  0,  0, 0
  };

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [15:0] pix_q [$];
  logic [15:0] w_q [$];
  int done_at;
  int done_cnt;
  bit done_seen;
  bit prev_done = 1'b0;
  logic busy_after_done;
  int first_w_cyc;
  int first_p_cyc;
  int start_cyc;
  int hs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Output monitor: registered outputs are stable on the falling edge.
  always @(negedge clk) begin
    if (valid_out) begin
      pix_q.push_back(pxl_out);
      if (first_p_cyc < 0) first_p_cyc = cycle;
    end
    if (valid_weight_out) begin
      w_q.push_back(weight_out);
      if (first_w_cyc < 0) first_w_cyc = cycle;
    end
    if (done) begin
      done_cnt++;
      done_seen = 1'b1;
      done_at = valid_out ? pix_q.size() : -1;
    end
    if (prev_done) busy_after_done = busy;
    prev_done = done;
  end

  task automatic write_w(input logic [3:0] addr, input logic [15:0] data);
    weight_we    = 1'b1;
    weight_addr  = addr;
    weight_wdata = data;
    @(negedge clk); #1;
    weight_we = 1'b0;
  endtask

  // Runs one frame starting in the current cycle. abort_at>0 asserts reset
  // once that many pixels were seen; inject drives a kernel write and a
  // second start twenty cycles into the frame.
  task automatic do_frame(input bit toggle, input int abort_at, input bit inject,
                          output int n_hs);
    int idx;
    int cyc;
    bit fin;
    idx = 0; cyc = 0; fin = 1'b0; n_hs = 0;
    pix_q.delete(); w_q.delete();
    done_at = 0; done_cnt = 0; done_seen = 1'b0; busy_after_done = 1'b1;
    first_w_cyc = -1; first_p_cyc = -1;
    start_cyc = cycle;
    while (!fin && cyc < 300) begin
      start        = (cyc == 0) || (inject && cyc == 20);
      weight_we    = inject && (cyc == 20);
      weight_addr  = 4'd3;
      weight_wdata = 16'hAAAA;
      valid_in     = (idx < 16) && (!toggle || (cyc % 2 == 0));
      pxl_in       = 16'(idx + 1);
      if (valid_in && in_ready) begin
        n_hs++;
        idx++;
      end
      @(negedge clk); #1;
      cyc++;
      if (done_seen) fin = 1'b1;
      if (abort_at > 0 && pix_q.size() >= abort_at) begin
        reset = 1'b1;
        fin   = 1'b1;
      end
    end
    start = 1'b0; weight_we = 1'b0; valid_in = 1'b0;
    if (!fin) check_eq("frame_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  // wmode: 0 = no weight phase, 1 = kernel 1..9, 2 = kernel all zero
  task automatic check_frame(input string nm, input int wmode, input int n_hs);
    check_eq({nm, " n_pix"}, pix_q.size(), 36);
    for (int i = 0; i < 36; i++)
      if (i < pix_q.size())
        check_eq($sformatf("%s pix[%0d]", nm, i), pix_q[i], exp_frame[i]);
    check_eq({nm, " handshakes"}, n_hs, 16);
    check_eq({nm, " done_at"}, done_at, 36);
    check_eq({nm, " done_cnt"}, done_cnt, 1);
    check_eq({nm, " busy_after_done"}, busy_after_done, 0);
    if (wmode == 0) begin
      check_eq({nm, " n_w"}, w_q.size(), 0);
      check_eq({nm, " first_pix_lat"}, first_p_cyc - start_cyc, 1);
    end else begin
      check_eq({nm, " n_w"}, w_q.size(), 9);
      for (int i = 0; i < 9; i++)
        if (i < w_q.size())
          check_eq($sformatf("%s w[%0d]", nm, i), w_q[i], (wmode == 1) ? i + 1 : 0);
      check_eq({nm, " first_w_lat"}, first_w_cyc - start_cyc, 1);
      check_eq({nm, " first_pix_lat"}, first_p_cyc - start_cyc, 10);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check_eq({nm, " weight_out"}, weight_out, 0);
    check_eq({nm, " valid_weight_out"}, valid_weight_out, 0);
    check_eq({nm, " pxl_out"}, pxl_out, 0);
    check_eq({nm, " valid_out"}, valid_out, 0);
    check_eq({nm, " busy"}, busy, 0);
    check_eq({nm, " done"}, done, 0);
    check_eq({nm, " in_ready"}, in_ready, 0);
  endtask

  initial begin
    reset = 1'b1; weight_we = 1'b0; weight_addr = '0; weight_wdata = '0;
    start = 1'b0; valid_in = 1'b0; pxl_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 9; i++) write_w(4'(i), 16'(i + 1));
    do_frame(1'b0, 0, 1'b0, hs);
    check_frame("f1", 1, hs);

    // Stalled input stream, kernel untouched since the last frame.
    do_frame(1'b1, 0, 1'b0, hs);
    check_frame("f2", REPLAY ? 1 : 0, hs);

    // Kernel write and start while busy: both dropped.
    do_frame(1'b0, 0, 1'b1, hs);
    check_frame("f3", REPLAY ? 1 : 0, hs);

    // Rewrite word 8 unchanged to mark the kernel dirty; word 3 must still be 4.
    write_w(4'd8, 16'd9);
    do_frame(1'b0, 0, 1'b0, hs);
    check_frame("f4", 1, hs);

    // Out-of-range address is not an accepted write.
    write_w(4'd12, 16'h5555);
    do_frame(1'b0, 0, 1'b0, hs);
    check_frame("f5", REPLAY ? 1 : 0, hs);

    // Reset in the middle of a frame.
    do_frame(1'b0, 20, 1'b0, hs);
    check_eq("abort n_pix", pix_q.size(), 20);
    check_idle_outputs("abort");
    reset = 1'b0;
    @(negedge clk); #1;

    do_frame(1'b0, 0, 1'b0, hs);
    check_frame("f7", 2, hs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_3x3_dilation_feeder.md
# conv_3x3_dilation_feeder

Stream source for the dilated 3x3 convolution datapath. Loads a 9-word kernel through a register-write port and, on each `start`, transmits the kernel on a weight stream, then converts a raw unpadded feature-map stream into the zero-padded raster stream the convolution input expects. The border is `RATE` pixels wide on every side. Sits directly upstream of the convolution top: `pxl_out`/`valid_out` drive its pixel input, and `weight_out`/`valid_weight_out` drive its weight input.

## Interface
Parameters:
- `DATA_WIDTH`, 16, pixel and weight word width
- `IMAGE_WIDTH`, 8, raw (unpadded) columns
- `IMAGE_HEIGHT`, 8, raw rows
- `RATE`, 2, dilation rate; also the padding width per side
- `KERNEL_SIZE`, 9, weights per kernel
- `CNT_WIDTH`, 8, width of the row/column counters; must hold `IMAGE_WIDTH+2*RATE`

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `weight_we`  in  1  kernel register write strobe
- `weight_addr`  in  4  kernel index 0..`KERNEL_SIZE`-1
- `weight_wdata`  in  `DATA_WIDTH`  kernel word
- `start`  in  1  begin one frame (pulse)
- `valid_in`  in  1  raw pixel present
- `pxl_in`  in  `DATA_WIDTH`  raw pixel
- `in_ready`  out  1  raw pixel is consumed this cycle when `valid_in` is also high
- `weight_out`  out  `DATA_WIDTH`  weight stream data
- `valid_weight_out`  out  1  weight stream valid
- `pxl_out`  out  `DATA_WIDTH`  padded pixel stream
- `valid_out`  out  1  padded pixel valid
- `busy`  out  1  a frame is in progress
- `done`  out  1  one-cycle pulse with the last padded pixel

## Operation
Derived sizes:
- PW = `IMAGE_WIDTH+2*RATE`
- PH = `IMAGE_HEIGHT+2*RATE`

FSM states:
- **IDLE**
  - `busy`=0.
  - `start` moves to WEIGHTS, or to PIXELS when the weights are skipped (see Configuration).
- **WEIGHTS**
  - Emits kernel words 0..`KERNEL_SIZE`-1, one per cycle, with `valid_weight_out`=1.
  - After index `KERNEL_SIZE`-1, moves to PIXELS.
- **PIXELS**
  - Row counter r runs 0..PH-1 and column counter c runs 0..PW-1, raster order.
  - Pad position: r<RATE, r≥RATE+IMAGE_HEIGHT, c<RATE, or c≥RATE+IMAGE_WIDTH.
    - Emits `pxl_out`=0 with `valid_out`=1 every cycle.
    - Never asserts `in_ready`.
  - Interior position:
    - `in_ready`=1, combinational from state and counters.
    - On `valid_in`&`in_ready`: emits `pxl_in` and advances.
    - Otherwise `valid_out`=0 and the counters hold (stall).
  - Counters advance only on an emitted pixel. c wraps at PW-1 and r then increments.
  - Emitting (PH-1, PW-1) pulses `done` and moves to IDLE.

Kernel registers and control:
- `weight_we` writes `weight_wdata` into kernel[`weight_addr`] only in IDLE.
- Writes while `busy`=1, and writes with `weight_addr`≥`KERNEL_SIZE`, are ignored.
- `start` while `busy`=1 is ignored.
- Exactly PW*PH pixel outputs and IMAGE_WIDTH*IMAGE_HEIGHT input handshakes occur per frame.

## Timing
- All outputs except `in_ready` are registered.
- Reset values:
  - `weight_out`=0, `valid_weight_out`=0, `pxl_out`=0, `valid_out`=0, `busy`=0, `done`=0, `in_ready`=0.
  - Counters=0, kernel registers=0, state IDLE, weight-dirty flag=1.
- Start latency: `start` sampled at edge N, so `busy`=1 and the first weight (or first pixel) are present after edge N+1.
- Weight phase takes `KERNEL_SIZE` cycles. The first pixel follows immediately after the last weight, with no gap cycle.
- Interior pixel latency: `pxl_in` accepted at edge N appears on `pxl_out` after edge N+1.
- `done` is high in the same cycle as the final `valid_out`. `busy` falls the following cycle.
- A new `start` is accepted in the cycle `busy` is 0, giving back-to-back frames with a one-cycle gap.
- Reset asserted mid-frame aborts immediately to reset values. A partial frame is never resumed.

## Configuration
- `CONV_FEEDER_WEIGHT_REPLAY_EN` defined:
  - Every `start` runs the WEIGHTS phase.
- Undefined:
  - A weight-dirty flag is set by reset or by any accepted `weight_we`.
  - `start` runs WEIGHTS only when the flag is set, and the flag clears at the end of WEIGHTS.
  - Otherwise `start` goes straight to PIXELS, and the first pixel appears after edge N+1.

## Test plan
- Reset, then load kernel 1..9 and `start` with `IMAGE_WIDTH`=`IMAGE_HEIGHT`=4, `RATE`=1, `valid_in` always 1, pixels 1..16 -> `valid_weight_out` high for 9 cycles with `weight_out` values 1..9, then 36 `valid_out` cycles.
  - Row 0 of the output is all zeros; row 1 is 0,1,2,3,4,0; row 5 is all zeros.
  - Exactly 16 `in_ready`&`valid_in` handshakes; `done` pulses with output #36.
- Same frame with `valid_in` toggling 1,0,1,0 -> pad pixels still emitted back-to-back, interior output gapped.
  - Output sequence is identical to the first scenario.
- Second `start` with no kernel write -> macro off: first pixel one cycle after `start`, no weights. Macro on: 9 weights first.
- `weight_we` to address 3 with value 0xAAAA while `busy`=1, and `start` while `busy`=1 -> both ignored.
  - Next frame transmits the original word 4.
- `reset` asserted at output #20 -> all outputs 0 on the next cycle, state IDLE.
  - A subsequent `start` replays the full frame from (0,0) with weights 0..0, since reset clears the kernel registers.
